// File: rtl/vga_timing_gen_if.sv
// rtl/vga_timing_gen_if.sv - raster timing bundle driven by vga_timing_gen
interface vga_timing_gen_if;
   logic        pixel_en;
   logic [15:0] hCount;
   logic [15:0] vCount;
   logic        bright;
   logic        frame_start;
   logic        bright_d;
   logic        hSync_n;
   logic        vSync_n;
   logic        vga_clk;

   modport master (
      output pixel_en, hCount, vCount, bright, frame_start,
      output bright_d, hSync_n, vSync_n, vga_clk
   );

   modport slave (
      input pixel_en, hCount, vCount, bright, frame_start,
      input bright_d, hSync_n, vSync_n, vga_clk
   );
endinterface

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing: pixel divider, h/v counters, delayed sync
// Sync and blanking are delayed PIPE_DELAY pixel ticks to line up with pixel memory reads.
module vga_timing_gen #(
   parameter int CLK_DIV    = 2,
   parameter int H_VISIBLE  = 640,
   parameter int H_FRONT    = 16,
   parameter int H_SYNC     = 96,
   parameter int H_BACK     = 48,
   parameter int V_VISIBLE  = 480,
   parameter int V_FRONT    = 10,
   parameter int V_SYNC     = 2,
   parameter int V_BACK     = 33,
   parameter int PIPE_DELAY = 1
) (
   input  logic             clk,
   input  logic             reset,
   vga_timing_gen_if.master vga
);

   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   localparam logic [15:0] H_LAST       = 16'(H_TOTAL - 1);
   localparam logic [15:0] V_LAST       = 16'(V_TOTAL - 1);
   localparam logic [15:0] H_VIS        = 16'(H_VISIBLE);
   localparam logic [15:0] V_VIS        = 16'(V_VISIBLE);
   localparam logic [15:0] H_SYNC_START = 16'(H_VISIBLE + H_FRONT);
   localparam logic [15:0] H_SYNC_END   = 16'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [15:0] V_SYNC_START = 16'(V_VISIBLE + V_FRONT);
   localparam logic [15:0] V_SYNC_END   = 16'(V_VISIBLE + V_FRONT + V_SYNC);

   localparam int              DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

   // {bright, hSync_n, vSync_n} while blanked with no sync active
   localparam logic [2:0] PIPE_IDLE = 3'b011;

   logic [DIV_W-1:0] divCount;
   logic [DIV_W-1:0] divNext;
   logic             pixelEn;
   logic [15:0]      hCount;
   logic [15:0]      vCount;
   logic             frameStart;
   logic             brightRaw;
   logic             hSyncRaw;
   logic             vSyncRaw;
   logic [2:0]       rawBits;
   logic [2:0]       delayedBits;

   always_comb begin
      divNext = divCount + DIV_W'(1);
      if (divCount == DIV_LAST) begin
         divNext = '0;
      end
   end

   // pixel_en fires for the clk after the divider reaches its last count
   always_ff @(posedge clk) begin
      if (reset) begin
         divCount <= '0;
         pixelEn  <= 1'b0;
      end else begin
         divCount <= divNext;
         pixelEn  <= (divCount == DIV_LAST);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hCount     <= '0;
         vCount     <= '0;
         frameStart <= 1'b0;
      end else begin
         frameStart <= pixelEn && (hCount == H_LAST) && (vCount == V_LAST);
         if (pixelEn) begin
            if (hCount == H_LAST) begin
               hCount <= '0;
               if (vCount == V_LAST) begin
                  vCount <= '0;
               end else begin
                  vCount <= vCount + 16'd1;
               end
            end else begin
               hCount <= hCount + 16'd1;
            end
         end
      end
   end

   always_comb begin
      brightRaw = (hCount < H_VIS) && (vCount < V_VIS);
      hSyncRaw  = !((hCount >= H_SYNC_START) && (hCount < H_SYNC_END));
      vSyncRaw  = !((vCount >= V_SYNC_START) && (vCount < V_SYNC_END));
      rawBits   = {brightRaw, hSyncRaw, vSyncRaw};
   end

   generate
      if (PIPE_DELAY == 0) begin : g_noPipe
         assign delayedBits = rawBits;
      end else begin : g_pipe
         logic [2:0] pipeQ [PIPE_DELAY];

         always_ff @(posedge clk) begin
            if (reset) begin
               for (int i = 0; i < PIPE_DELAY; i++) begin
                  pipeQ[i] <= PIPE_IDLE;
               end
            end else if (pixelEn) begin
               pipeQ[0] <= rawBits;
               for (int i = 1; i < PIPE_DELAY; i++) begin
                  pipeQ[i] <= pipeQ[i-1];
               end
            end
         end

         assign delayedBits = pipeQ[PIPE_DELAY-1];
      end
   endgenerate

   // With no divider the DAC clock degenerates to the always-on pixel strobe
   generate
      if (CLK_DIV == 1) begin : g_div1
         assign vga.vga_clk = pixelEn;
      end else begin : g_divN
         logic vgaClkQ;

         always_ff @(posedge clk) begin
            if (reset) begin
               vgaClkQ <= 1'b0;
            end else begin
               vgaClkQ <= (divNext >= DIV_HALF);
            end
         end

         assign vga.vga_clk = vgaClkQ;
      end
   endgenerate

   assign vga.pixel_en    = pixelEn;
   assign vga.hCount      = hCount;
   assign vga.vCount      = vCount;
   assign vga.bright      = brightRaw;
   assign vga.frame_start = frameStart;
   assign vga.bright_d    = delayedBits[2];
   assign vga.hSync_n     = delayedBits[1];
   assign vga.vSync_n     = delayedBits[0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed checks of vga_timing_gen at three parameter points
module tb_vga_timing_gen;

   logic clk = 1'b0;
   logic rstA = 1'b1;
   logic rstB = 1'b1;
   logic rstC = 1'b1;

   always #5 clk = ~clk;

   vga_timing_gen_if ifA();
   vga_timing_gen_if ifB();
   vga_timing_gen_if ifC();

   // A: default 640x480 timing
   vga_timing_gen dutA (.clk(clk), .reset(rstA), .vga(ifA));

   // B: 30x15 raster, divide by 3, two-tick delay line
   vga_timing_gen #(
      .CLK_DIV(3), .H_VISIBLE(16), .H_FRONT(4), .H_SYNC(6), .H_BACK(4),
      .V_VISIBLE(8), .V_FRONT(2), .V_SYNC(2), .V_BACK(3), .PIPE_DELAY(2)
   ) dutB (.clk(clk), .reset(rstB), .vga(ifB));

   // C: 30x15 raster, no divider, no delay
   vga_timing_gen #(
      .CLK_DIV(1), .H_VISIBLE(16), .H_FRONT(4), .H_SYNC(6), .H_BACK(4),
      .V_VISIBLE(8), .V_FRONT(2), .V_SYNC(2), .V_BACK(3), .PIPE_DELAY(0)
   ) dutC (.clk(clk), .reset(rstC), .vga(ifC));

   typedef struct {
      logic        peA;
      logic [15:0] hA;
      logic        vclkA;
      logic        bdA;
      logic        peC;
      logic [15:0] hC;
   } row_t;

   row_t rows [8];

   int checks = 0;
   int failures = 0;

   int cyc, h, v, tick, expH;
   int lowCnt, firstLow, lagErr, wrapH, wrapV, prevH, b639, b640;
   int fsCnt, fsH, fsV, vsLow, hsLowB, firstB, leak, cErr, cPe;
   bit wrapSeen, found;
   logic expBit;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   initial begin
      rows[0] = '{1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 16'd0};
      rows[1] = '{1'b0, 16'd0, 1'b1, 1'b0, 1'b1, 16'd0};
      rows[2] = '{1'b1, 16'd0, 1'b0, 1'b0, 1'b1, 16'd1};
      rows[3] = '{1'b0, 16'd1, 1'b1, 1'b1, 1'b1, 16'd2};
      rows[4] = '{1'b1, 16'd1, 1'b0, 1'b1, 1'b1, 16'd3};
      rows[5] = '{1'b0, 16'd2, 1'b1, 1'b1, 1'b1, 16'd4};
      rows[6] = '{1'b1, 16'd2, 1'b0, 1'b1, 1'b1, 16'd5};
      rows[7] = '{1'b0, 16'd3, 1'b1, 1'b1, 1'b1, 16'd6};

      repeat (3) @(posedge clk);
      @(negedge clk);

      // Row 0 is the held-in-reset state; later rows follow each clk after release
      for (int k = 0; k < 8; k++) begin
         if (k > 0) @(negedge clk);
         check($sformatf("a_pe_k%0d", k), ifA.pixel_en, rows[k].peA);
         check($sformatf("a_h_k%0d", k), ifA.hCount, rows[k].hA);
         check($sformatf("a_vclk_k%0d", k), ifA.vga_clk, rows[k].vclkA);
         check($sformatf("a_bd_k%0d", k), ifA.bright_d, rows[k].bdA);
         check($sformatf("a_hs_k%0d", k), ifA.hSync_n, 1'b1);
         check($sformatf("a_fs_k%0d", k), ifA.frame_start, 1'b0);
         check($sformatf("c_pe_k%0d", k), ifC.pixel_en, rows[k].peC);
         check($sformatf("c_h_k%0d", k), ifC.hCount, rows[k].hC);
         if (k == 0) begin
            check("a_v_reset", ifA.vCount, 0);
            check("a_vs_reset", ifA.vSync_n, 1'b1);
            rstA = 1'b0;
            rstC = 1'b0;
         end
      end

      // C: one count per clk, sync follows the raw window with no lag
      cErr = 0;
      cPe = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         expH = (7 + i) % 30;
         expBit = !(expH >= 20 && expH < 26);
         if (ifC.hCount != 16'(expH)) cErr++;
         if (ifC.hSync_n !== expBit) cErr++;
         if (ifC.pixel_en !== 1'b1) cPe++;
      end
      check("c_track_err", cErr, 0);
      check("c_pe_gaps", cPe, 0);

      // A: scan the rest of line 0 up to the wrap into line 1
      cyc = 0; lowCnt = 0; firstLow = -1; lagErr = 0; wrapSeen = 0;
      wrapH = -1; wrapV = -1; prevH = -1; b639 = 2; b640 = 2;
      while (!wrapSeen && cyc < 2000) begin
         @(negedge clk);
         cyc++;
         if (ifA.pixel_en) begin
            h = int'(ifA.hCount);
            v = int'(ifA.vCount);
            if (prevH == 799) begin
               wrapSeen = 1;
               wrapH = h;
               wrapV = v;
            end
            prevH = h;
            if (v == 0 && ifA.hSync_n == 1'b0) begin
               lowCnt++;
               if (firstLow < 0) firstLow = h;
            end
            expBit = (h > 0) ? ((h - 1) < 640 && v < 480) : 1'b0;
            if (ifA.bright_d !== expBit) lagErr++;
            if (h == 639) b639 = int'(ifA.bright);
            if (h == 640) b640 = int'(ifA.bright);
         end
      end
      check("a_wrap_seen", wrapSeen, 1);
      check("a_wrap_h", wrapH, 0);
      check("a_wrap_v", wrapV, 1);
      check("a_hsync_low_ticks", lowCnt, 96);
      check("a_hsync_first_h", firstLow, 657);
      check("a_bright_d_lag_err", lagErr, 0);
      check("a_bright_639", b639, 1);
      check("a_bright_640", b640, 0);

      // B: reset state, then a frame and a bit
      @(negedge clk);
      check("b_rst_pe", ifB.pixel_en, 1'b0);
      check("b_rst_fs", ifB.frame_start, 1'b0);
      check("b_rst_bd", ifB.bright_d, 1'b0);
      check("b_rst_hs", ifB.hSync_n, 1'b1);
      check("b_rst_vs", ifB.vSync_n, 1'b1);
      check("b_rst_vclk", ifB.vga_clk, 1'b0);
      rstB = 1'b0;

      cyc = 0; tick = 0; fsCnt = 0; fsH = -1; fsV = -1; vsLow = 0; hsLowB = 0; firstB = -1;
      while (tick < 460 && cyc < 2000) begin
         @(negedge clk);
         cyc++;
         if (ifB.frame_start) begin
            fsCnt++;
            fsH = int'(ifB.hCount);
            fsV = int'(ifB.vCount);
         end
         if (ifB.pixel_en) begin
            tick++;
            if (ifB.vSync_n == 1'b0) vsLow++;
            if (ifB.vCount == 16'd0 && ifB.hSync_n == 1'b0) begin
               hsLowB++;
               if (firstB < 0) firstB = int'(ifB.hCount);
            end
         end
      end
      check("b_ticks", tick, 460);
      check("b_fs_count", fsCnt, 1);
      check("b_fs_h", fsH, 0);
      check("b_fs_v", fsV, 0);
      check("b_vsync_low_ticks", vsLow, 60);
      check("b_hsync_low_ticks", hsLowB, 6);
      check("b_hsync_first_h", firstB, 22);

      // B: reset inside both sync windows
      cyc = 0; found = 0;
      while (!found && cyc < 1500) begin
         @(negedge clk);
         cyc++;
         if (ifB.pixel_en && ifB.hCount == 16'd22 && ifB.vCount == 16'd11) found = 1;
      end
      check("b_mid_found", found, 1);
      check("b_pre_hs", ifB.hSync_n, 1'b0);
      check("b_pre_vs", ifB.vSync_n, 1'b0);
      rstB = 1'b1;
      @(negedge clk);
      check("b_mid_h", ifB.hCount, 0);
      check("b_mid_v", ifB.vCount, 0);
      check("b_mid_hs", ifB.hSync_n, 1'b1);
      check("b_mid_vs", ifB.vSync_n, 1'b1);
      check("b_mid_bd", ifB.bright_d, 1'b0);
      check("b_mid_fs", ifB.frame_start, 1'b0);
      check("b_mid_pe", ifB.pixel_en, 1'b0);
      rstB = 1'b0;

      leak = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (ifB.hSync_n !== 1'b1 || ifB.vSync_n !== 1'b1 || ifB.frame_start !== 1'b0) leak++;
      end
      check("b_post_leak", leak, 0);
      check("b_post_h", ifB.hCount, 13);
      check("b_post_v", ifB.vCount, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
